// File: rtl/stage_elastic_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_elastic_buf                                                        |
// | DEPTH-entry elastic valid/ready FIFO between pipeline stages, with a     |
// | synchronous flush. Optional build macro STAGE_ELASTIC_BUF_BYPASS_EN      |
// | enables zero-latency pass-through when empty.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stage_elastic_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("stage_elastic_buf: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         w_occ;
    logic                  w_empty, w_full, w_push, w_pop, w_pass;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign w_occ   = wptr_q - rptr_q;
    assign count   = CNT_W'(w_occ);
    assign s_ready = ~w_full;

`ifdef STAGE_ELASTIC_BUF_BYPASS_EN
    assign w_pass  = w_empty & s_valid & m_ready & ~flush;
    assign m_valid = w_empty ? (s_valid & ~flush) : 1'b1;
    assign m_data  = w_empty ? s_data : mem_q[rptr_q[AW-1:0]];
`else
    assign w_pass  = 1'b0;
    assign m_valid = ~w_empty;
    assign m_data  = mem_q[rptr_q[AW-1:0]];
`endif

    assign w_push = s_valid & s_ready & ~flush & ~w_pass;
    assign w_pop  = ~w_empty & m_ready & ~flush;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = rptr_q;
        end else begin
            if (w_push) wptr_d = wptr_q + PW'(1);
            if (w_pop)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Payload storage is deliberately not reset; m_data is don't-care when invalid.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q[AW-1:0]] <= s_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_stage_elastic_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_stage_elastic_buf                                                     |
// | Self-checking bench for stage_elastic_buf (DEPTH=4) against a queue model|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_stage_elastic_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef STAGE_ELASTIC_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk, rst, flush, s_valid, s_ready, m_valid, m_ready;
    logic [DW-1:0] s_data, m_data;
    logic [CW-1:0] count;

    int tests_run = 0;
    int fails     = 0;

    logic [DW-1:0] mq[$];

    stage_elastic_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs from the current model contents and current inputs.
    function automatic void model_exp(output logic ev, output logic [DW-1:0] ed,
                                      output logic er, output int ec);
        ec = mq.size();
        er = (ec < DEPTH);
        if (ec > 0) begin
            ev = 1'b1;
            ed = mq[0];
        end else begin
            ev = BYP ? (s_valid & ~flush) : 1'b0;
            ed = s_data;
        end
    endfunction

    function automatic void model_tick();
        logic ev, er;
        logic [DW-1:0] ed;
        int ec;
        if (!rst || flush) begin
            mq.delete();
        end else begin
            model_exp(ev, ed, er, ec);
            if (ev && m_ready && ec == 0) begin
                // pass-through: nothing stored
            end else begin
                if (ev && m_ready) void'(mq.pop_front());
                if (s_valid && er) mq.push_back(s_data);
            end
        end
    endfunction

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drain();
        s_valid = 1'b0; m_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        logic ev, er; logic [DW-1:0] ed; int ec;
        rst = 1'b0; flush = 1'b0; m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        tick(); tick();
        settle();
        tests_run++;
        if (count !== '0) begin fails++; $display("FAIL reset_count_held: got %0d want 0", count); end
        rst = 1'b1;
        settle();
        model_exp(ev, ed, er, ec);
        tests_run++;
        if (m_valid !== ev || count !== CW'(0) || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: m_valid=%b count=%0d s_ready=%b want %b/0/1", m_valid, count, s_ready, ev);
        end
        tick();
        settle();
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 32'hDEAD_BEEF || int'(count) != mq.size()) begin
            fails++;
            $display("FAIL reset_first_push: m_valid=%b m_data=%h count=%0d want 1/deadbeef/%0d", m_valid, m_data, count, mq.size());
        end
        drain();
    endtask

    task automatic test_fill_stall();
        logic [DW-1:0] got[$];
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            tick();
            settle();
            tests_run++;
            if (int'(count) != i) begin fails++; $display("FAIL fill_count: got %0d want %0d", count, i); end
        end
        tests_run++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL fill_full_ready: got %b want 0", s_ready); end
        s_data = 32'd5; m_ready = 1'b1;
        for (int c = 0; c < 12 && got.size() < 5; c++) begin
            settle();
            if (m_valid) got.push_back(m_data);
            if (s_valid && s_ready) begin
                tick();
                s_valid = 1'b0;
            end else begin
                tick();
            end
        end
        tests_run++;
        if (got.size() != 5) begin
            fails++; $display("FAIL fill_drain_len: got %0d want 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (got[k] !== DW'(k + 1)) begin fails++; $display("FAIL fill_drain_order[%0d]: got %0d want %0d", k, got[k], k + 1); end
            end
        end
        drain();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] got[$];
        int bad_cnt = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 23; i++) begin
            s_valid = (i < 20); s_data = DW'(i);
            settle();
            if (i >= 1 && i < 20 && int'(count) != (BYP ? 0 : 1)) bad_cnt++;
            if (m_valid) got.push_back(m_data);
            tick();
        end
        tests_run++;
        if (bad_cnt != 0) begin fails++; $display("FAIL stream_count: %0d cycles off steady value %0d", bad_cnt, BYP ? 0 : 1); end
        tests_run++;
        if (got.size() != 20) begin
            fails++; $display("FAIL stream_len: got %0d want 20", got.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                tests_run++;
                if (got[k] !== DW'(k)) begin fails++; $display("FAIL stream_order[%0d]: got %0d want %0d", k, got[k], k); end
            end
        end
        drain();
    endtask

    task automatic test_simul();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 32'h30 + DW'(i);
            tick();
        end
        s_data = 32'h33; m_ready = 1'b1;
        settle();
        tests_run++;
        if (count !== CW'(3) || s_ready !== 1'b1 || m_data !== 32'h30) begin
            fails++; $display("FAIL simul_before: count=%0d s_ready=%b m_data=%h want 3/1/30", count, s_ready, m_data);
        end
        tick();
        s_valid = 1'b0; m_ready = 1'b0;
        settle();
        tests_run++;
        if (count !== CW'(3) || s_ready !== 1'b1 || m_data !== 32'h31) begin
            fails++; $display("FAIL simul_after: count=%0d s_ready=%b m_data=%h want 3/1/31", count, s_ready, m_data);
        end
        drain();
    endtask

    task automatic test_flush();
        logic [DW-1:0] first;
        bit seen = 0;
        m_ready = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            tick();
        end
        flush = 1'b1; s_data = 32'd10;
        tick();
        flush = 1'b0; s_valid = 1'b0;
        settle();
        tests_run++;
        if (count !== '0 || m_valid !== 1'b0) begin
            fails++; $display("FAIL flush_clear: count=%0d m_valid=%b want 0/0", count, m_valid);
        end
        s_valid = 1'b1; s_data = 32'd11; m_ready = 1'b1;
        for (int c = 0; c < 4 && !seen; c++) begin
            settle();
            if (m_valid) begin seen = 1; first = m_data; end
            tick();
            s_valid = 1'b0;
        end
        tests_run++;
        if (!seen || first !== 32'd11) begin
            fails++; $display("FAIL flush_next_head: seen=%0d got %0d want 11", seen, first);
        end
        drain();
    endtask

    task automatic test_bypass();
        s_valid = 1'b1; m_ready = 1'b1; s_data = 32'h1234;
        settle();
        tests_run++;
        if (m_valid !== BYP || (BYP && m_data !== 32'h1234) || count !== '0) begin
            fails++; $display("FAIL bypass_same_cycle: m_valid=%b m_data=%h count=%0d want %b/1234/0", m_valid, m_data, count, BYP);
        end
        tick();
        s_valid = 1'b0;
        settle();
        tests_run++;
        if (m_valid !== !BYP || (!BYP && m_data !== 32'h1234)) begin
            fails++; $display("FAIL bypass_next_cycle: m_valid=%b m_data=%h want %b/1234", m_valid, m_data, !BYP);
        end
        drain();
    endtask

    task automatic test_random();
        logic ev, er; logic [DW-1:0] ed; int ec;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            s_data  = $urandom;
            settle();
            model_exp(ev, ed, er, ec);
            tests_run++;
            if (m_valid !== ev || s_ready !== er || int'(count) != ec || (ev && m_data !== ed)) begin
                fails++; bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: v=%b r=%b c=%0d d=%h want v=%b r=%b c=%0d d=%h",
                             i, m_valid, s_ready, count, m_data, ev, er, ec, ed);
            end
            tick();
        end
        drain();
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        test_reset();
        test_fill_stall();
        test_streaming();
        test_simul();
        test_flush();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_elastic_buf.md
Name: stage_elastic_buf

Overview:
- Parametrised successor to the single-entry valid/ready stage registers that sit between the F/D/X/M/W stages of npc.
- Each instance is a DEPTH-entry elastic FIFO carrying an opaque DATA_WIDTH payload (the stage bundle concatenated by the instantiating stage).
- Provides full throughput, no combinational s_ready-from-m_ready path, and a synchronous flush for redirect (branch/jump/ecall/mret kill of younger work).
- Drop-in between any two npc stages.

Parameters:
- DATA_WIDTH, 32, payload width in bits, legal range 1..1024.
- DEPTH, 2, number of entries; must be a power of two, >=2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy output; derived, never overridden.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets the block immediately.
- flush  input  1  synchronous kill of all held entries and of the same-cycle push.
- s_valid  input  1  upstream has payload.
- s_ready  output  1  buffer can accept.
- s_data  input  DATA_WIDTH  upstream payload.
- m_valid  output  1  head entry available.
- m_ready  input  1  downstream accepts.
- m_data  output  DATA_WIDTH  head payload.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DATA_WIDTH array plus wptr/rptr of $clog2(DEPTH)+1 bits (extra wrap bit).
  - full = (ptrs equal except MSB); empty = (ptrs equal).
  - count = wptr - rptr, truncated to CNT_W.
- Reset (rst=0, async):
  - wptr=rptr=0, count=0, m_valid=0, s_ready=1 (once rst deasserts).
  - Array contents are not reset; m_data is don't-care while m_valid=0.
- push = s_valid & s_ready & ~flush; pop = m_valid & m_ready & ~flush.
- s_ready = ~full. It depends only on registered state, never on m_ready or s_valid.
- m_valid = ~empty; m_data = array[rptr] (combinational read of the registered head).
- Latency: a pushed payload is visible on m_valid/m_data the cycle after the push edge (1-cycle) in the base build.
- Push and pop in the same cycle: both take effect; count unchanged.
  - Legal at any occupancy 1..DEPTH-1.
  - At full, push is impossible (s_ready=0) even if m_ready=1. DEPTH>=2 therefore still sustains one transfer per cycle.
- Pointer wrap: low bits wrap modulo DEPTH, MSB toggles. No special casing.
- Flush:
  - On the edge with flush=1, wptr<=rptr, so count=0 and m_valid=0 the next cycle.
  - s_data offered that cycle is dropped, even though s_ready may read 1.
  - m_valid may be 1 during the flush cycle, but the downstream must treat it as killed: pop is suppressed, and the entry is discarded by the flush, not consumed.
- Flush while empty: no effect.
- Flush and reset together: reset wins.
- Reset mid-transfer: all entries lost; no partial payload is ever presented.
- Payload stability: while m_valid=1 and m_ready=0, m_data holds stable. Upstream must hold s_data stable while s_valid=1 and s_ready=0; the block does not check this.
- Overflow/underflow are impossible by construction; no error outputs.

Optional Feature:
- STAGE_ELASTIC_BUF_BYPASS_EN, zero-latency pass-through when empty.
- When defined and empty=1:
  - m_valid = s_valid & ~flush and m_data = s_data.
  - If m_ready=1 in that cycle, the payload passes through and is not written; pointers are unchanged.
  - If m_ready=0, it is written as a normal push.
- s_ready remains ~full, so a combinational s_valid->m_valid path exists, but there is still no m_ready->s_ready path.
- When undefined, latency is exactly 1 cycle as above.

Test Plan:
- Reset: hold rst=0 with s_valid=1, s_data=32'hDEAD_BEEF; release -> m_valid=0, count=0, s_ready=1. With s_valid held, m_valid=1 and m_data=32'hDEAD_BEEF one cycle after the first push.
- Fill/stall (DEPTH=4): m_ready=0, push 1,2,3,4 on consecutive cycles -> count 1,2,3,4; s_ready=0 after the 4th. A 5th payload of 5 is held upstream. Release m_ready -> outputs 1,2,3,4,5 in order.
- Streaming: s_valid=m_ready=1 for 20 cycles with an incrementing payload 0..19 -> one output per cycle, count steady at 1, order preserved. Pointer wrap is exercised (20 > 2*DEPTH).
- Simultaneous push/pop at count=3 (DEPTH=4) -> count stays 3, s_ready stays 1, head advances by one.
- Flush: count=3 holding 7,8,9, flush=1 with s_valid=1, s_data=10 -> next cycle count=0, m_valid=0. Payload 10 never appears; the next push of 11 is output first.
- Bypass (macro defined): empty, s_valid=m_ready=1, s_data=32'h1234 -> m_valid=1, m_data=32'h1234 in the same cycle, and count remains 0. Without the macro, the same stimulus gives m_valid=0 that cycle and 1 the next.
